rdiv_arbiter: RTL and testbench
===============================

RDIV_ARBITER -- requirements
Module: rdiv_arbiter

Interface
REQ-001 SHALL have parameter DIV_LOG2, default 3, meaning log2 of the power-of-two divisor.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, meaning quotient width.
REQ-003 SHALL have parameter IN_WIDTH, default OUT_WIDTH+DIV_LOG2, meaning dividend width.
REQ-004 SHALL have port clk  input  1  the single clock; all state is on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports in0_valid / in1_valid  input  1  requester N presents a dividend.
REQ-007 SHALL have ports in0_data / in1_data  input  IN_WIDTH  dividend of requester N.
REQ-008 SHALL have ports in0_ready / in1_ready  output  1  requester N is accepted this cycle.
REQ-009 SHALL have port out_valid  output  1  result register holds a result.
REQ-010 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-011 SHALL have port out_data  output  OUT_WIDTH  rounded quotient.
REQ-012 SHALL have port out_src  output  1  index of the requester that produced out_data.
REQ-013 SHALL have port out_sat  output  1  the result was clamped at the all-ones value.
REQ-014 SHALL have port sat_count  output  16  number of saturated results since reset.

Function
REQ-015 SHALL compute result = din[IN_WIDTH-1:DIV_LOG2] + din[DIV_LOG2-1]: round half up.
REQ-016 SHALL, when the integer part is all ones and din[DIV_LOG2-1]=1, output all ones with out_sat=1; otherwise out_sat=0.
REQ-017 SHALL define slot_free = !out_valid || out_ready, evaluated combinationally.
REQ-018 SHALL assert at most one inN_ready per cycle, and only when slot_free=1 and inN_valid=1.
REQ-019 SHALL grant the only valid requester when exactly one inN_valid=1.
REQ-020 SHALL, when both are valid, grant the requester other than rr_last, the index of the last granted requester.
REQ-021 SHALL update rr_last only on an accepted transfer (inN_valid && inN_ready).
REQ-022 SHALL, on an accepted transfer, register out_data, out_src and out_sat and set out_valid=1 on the next edge: latency one cycle.
REQ-023 SHALL clear out_valid when out_valid && out_ready and no new transfer occurs that cycle.
REQ-024 SHALL, on consume and accept in the same cycle, replace the register with the new result with out_valid held at 1 (full throughput, no bubble).
REQ-025 SHALL hold out_data, out_src and out_sat stable while out_valid=1 and out_ready=0.
REQ-026 SHALL increment sat_count by 1 on each accepted transfer with saturation, and stick at 0xFFFF.
REQ-027 SHALL allow inN_ready to depend combinationally on in0_valid, in1_valid and out_ready.
REQ-028 SHALL leave inN_ready independent of inN_data.

Reset
REQ-029 SHALL, while resetn=0, force out_valid=0, out_data=0, out_src=0, out_sat=0, sat_count=0 and rr_last=1, so requester 0 wins first.
REQ-030 SHALL discard an undelivered result on a mid-operation reset, and deassert inN_ready during reset.
REQ-031 SHALL resume arbitration on the first rising edge after resetn deasserts.

Structure
REQ-032 SHALL place the default DIV_LOG2 and OUT_WIDTH values and the SAT_CNT_W=16 constant in the shared package rdiv_pkg.
REQ-033 SHALL implement the rounding and saturation datapath (REQ-015/016) as the combinational sub-module rdiv_round, instantiated once.
REQ-034 SHALL keep the arbiter, result register and counter in rdiv_arbiter.

Verification (DIV_LOG2=3, OUT_WIDTH=32)
REQ-035 SHALL check: in0 sends 0x13 (2.375) -> out_data=2, out_src=0, out_sat=0 one cycle later.
REQ-036 SHALL check: in1 sends 0x14 (2.5) -> out_data=3, out_src=1.
REQ-037 SHALL check: in0 sends 0x7_FFFF_FFFF -> out_data=0xFFFFFFFF, out_sat=1, sat_count=1.
REQ-038 SHALL check: both valid for 4 cycles with out_ready=1 -> out_src sequence 0,1,0,1 with out_valid held 1.
REQ-039 SHALL check: out_ready=0 for 3 cycles while both are valid -> out_data stable, both inN_ready=0; on release, next grant goes to the non-last requester.
REQ-040 SHALL check: resetn pulsed low while out_valid=1 -> out_valid=0 and sat_count=0 immediately, and the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/rdiv_pkg.sv
// Shared constants and types for the rounding-divider arbiter.
//   DIV_LOG2_DEF  - default log2 of the power-of-two divisor
//   OUT_WIDTH_DEF - default quotient width
//   SAT_CNT_W     - width of the saturation event counter
//   src_e         - requester index (also the round-robin "last granted" marker)
package rdiv_pkg;

   localparam int unsigned DIV_LOG2_DEF  = 3;
   localparam int unsigned OUT_WIDTH_DEF = 32;
   localparam int unsigned SAT_CNT_W     = 16;

   typedef enum logic {
      SRC0 = 1'b0,
      SRC1 = 1'b1
   } src_e;

endpackage

// File: rtl/rdiv_if.sv
// Handshake bundle between two requesters, the arbiter and the result consumer.
//   in0_valid/in0_data/in0_ready - requester 0 dividend handshake
//   in1_valid/in1_data/in1_ready - requester 1 dividend handshake
//   out_valid/out_ready          - result handshake towards the consumer
//   out_data/out_src/out_sat     - rounded quotient, producing requester, clamp flag
// Modports: slave = arbiter side, master = requester/consumer side.
interface rdiv_if
   import rdiv_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = OUT_WIDTH_DEF + DIV_LOG2_DEF,
   parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF
);

   logic                 in0_valid;
   logic [IN_WIDTH-1:0]  in0_data;
   logic                 in0_ready;
   logic                 in1_valid;
   logic [IN_WIDTH-1:0]  in1_data;
   logic                 in1_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_src;
   logic                 out_sat;

   modport slave (
      input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
      output in0_ready, in1_ready, out_valid, out_data, out_src, out_sat
   );

   modport master (
      output in0_valid, in0_data, in1_valid, in1_data, out_ready,
      input  in0_ready, in1_ready, out_valid, out_data, out_src, out_sat
   );

endinterface

// File: rtl/rdiv_round.sv
// Combinational divide-by-2^DIV_LOG2 with round-half-up and clamp at all ones.
//   din_i - dividend
//   q_o   - rounded quotient (all ones when the round-up would overflow)
//   sat_o - asserted when the quotient was clamped
module rdiv_round
   import rdiv_pkg::*;
#(
   parameter int unsigned DIV_LOG2  = DIV_LOG2_DEF,
   parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF,
   parameter int unsigned IN_WIDTH  = OUT_WIDTH + DIV_LOG2
) (
   input  logic [IN_WIDTH-1:0]  din_i,
   output logic [OUT_WIDTH-1:0] q_o,
   output logic                 sat_o
);

   logic [OUT_WIDTH-1:0] int_part;
   logic                 half_bit;

   assign int_part = din_i[DIV_LOG2 +: OUT_WIDTH];
   assign half_bit = din_i[DIV_LOG2-1];

   // Only the overflowing round-up case saturates.
   assign sat_o = (&int_part) & half_bit;
   assign q_o   = sat_o ? '1 : int_part + OUT_WIDTH'(half_bit);

   // Bits below the half bit never influence a round-half-up result.
   if (DIV_LOG2 > 1) begin : g_lsbs
      logic unused_lsbs;
      assign unused_lsbs = ^din_i[DIV_LOG2-2:0];
   end

endmodule

// File: rtl/rdiv_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry result register through
// the rdiv_round datapath.
//   clk       - clock, rising edge
//   resetn    - asynchronous active-low reset
//   bus       - handshake bundle (slave side), see rdiv_if
//   sat_count - saturating count of clamped results accepted since reset
module rdiv_arbiter
   import rdiv_pkg::*;
#(
   parameter int unsigned DIV_LOG2  = DIV_LOG2_DEF,
   parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF,
   parameter int unsigned IN_WIDTH  = OUT_WIDTH + DIV_LOG2
) (
   input  logic                 clk,
   input  logic                 resetn,
   rdiv_if.slave                bus,
   output logic [SAT_CNT_W-1:0] sat_count
);

   logic                 slot_free;
   logic                 grant0;
   logic                 grant1;
   logic                 accept;
   logic [IN_WIDTH-1:0]  sel_data;
   logic [OUT_WIDTH-1:0] rnd_q;
   logic                 rnd_sat;

   logic                 out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0] out_data_q,  out_data_d;
   src_e                 out_src_q,   out_src_d;
   logic                 out_sat_q,   out_sat_d;
   logic [SAT_CNT_W-1:0] sat_cnt_q,   sat_cnt_d;
   src_e                 rr_last_q,   rr_last_d;

   // Grant logic looks only at valids, out_ready and the round-robin pointer,
   // never at the data; readies are held low while reset is asserted.
   always_comb begin
      slot_free = !out_valid_q || bus.out_ready;
      grant0    = 1'b0;
      grant1    = 1'b0;
      if (resetn && slot_free) begin
         if (bus.in0_valid && bus.in1_valid) begin
            if (rr_last_q == SRC0) grant1 = 1'b1;
            else                   grant0 = 1'b1;
         end else begin
            grant0 = bus.in0_valid;
            grant1 = bus.in1_valid;
         end
      end
      accept   = grant0 || grant1;
      sel_data = grant1 ? bus.in1_data : bus.in0_data;
   end

   rdiv_round #(
      .DIV_LOG2  (DIV_LOG2),
      .OUT_WIDTH (OUT_WIDTH),
      .IN_WIDTH  (IN_WIDTH)
   ) u_round (
      .din_i (sel_data),
      .q_o   (rnd_q),
      .sat_o (rnd_sat)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_sat_d   = out_sat_q;
      sat_cnt_d   = sat_cnt_q;
      rr_last_d   = rr_last_q;
      if (accept) begin
         // Covers consume-and-refill in one cycle: valid simply stays high.
         out_valid_d = 1'b1;
         out_data_d  = rnd_q;
         out_src_d   = grant1 ? SRC1 : SRC0;
         out_sat_d   = rnd_sat;
         rr_last_d   = grant1 ? SRC1 : SRC0;
         if (rnd_sat && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // rr_last resets to 1 so requester 0 wins the first contested grant.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= SRC0;
         out_sat_q   <= 1'b0;
         sat_cnt_q   <= '0;
         rr_last_q   <= SRC1;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_sat_q   <= out_sat_d;
         sat_cnt_q   <= sat_cnt_d;
         rr_last_q   <= rr_last_d;
      end
   end

   assign bus.in0_ready = grant0;
   assign bus.in1_ready = grant1;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign bus.out_sat   = out_sat_q;
   assign sat_count     = sat_cnt_q;

endmodule

// File: tb/tb_rdiv_arbiter.sv
module tb_rdiv_arbiter;

   localparam int unsigned DL = 3;
   localparam int unsigned OW = 32;
   localparam int unsigned IW = OW + DL;

   logic        clk;
   logic        resetn;
   logic [15:0] sat_count;

   int checks = 0;
   int errors = 0;

   rdiv_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

   rdiv_arbiter #(
      .DIV_LOG2  (DL),
      .OUT_WIDTH (OW),
      .IN_WIDTH  (IW)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .sat_count (sat_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   typedef struct {
      string       name;
      logic        v0;
      logic        v1;
      logic [34:0] d0;
      logic [34:0] d1;
      logic        ordy;
      logic        r0;
      logic        r1;
      logic        ov;
      logic [31:0] od;
      logic        os;
      logic        osat;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[10];

   // Reference model state
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_src;
   logic        m_sat;
   int unsigned m_cnt;
   int          m_last;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Divide by 8 with round half up, clamped to 32 bits, in plain integer arithmetic.
   function automatic void model_div(input logic [34:0] d, output logic [31:0] q, output logic s);
      longint unsigned dd;
      longint unsigned r;
      dd = {29'b0, d};
      r  = (dd / 8) + ((dd % 8) >= 4 ? 1 : 0);
      if (r > 64'h0000_0000_FFFF_FFFF) begin
         q = 32'hFFFF_FFFF;
         s = 1'b1;
      end else begin
         q = r[31:0];
         s = 1'b0;
      end
   endfunction

   task automatic drive(input logic v0, input logic v1, input logic [34:0] d0,
                        input logic [34:0] d1, input logic ordy);
      bus.in0_valid = v0;
      bus.in1_valid = v1;
      bus.in0_data  = d0;
      bus.in1_data  = d1;
      bus.out_ready = ordy;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 1'b0;
      m_sat   = 1'b0;
      m_cnt   = 0;
      m_last  = 1;
   endtask

   initial begin
      int g;
      logic        e0, e1;
      logic [31:0] q;
      logic        s;
      logic [34:0] d0, d1;
      logic        v0, v1, ordy;

      vecs[0] = '{"in0_2p375", 1, 0, 35'h13, 35'h0, 1, 1, 0, 1, 32'd2, 0, 0, 16'd0};
      vecs[1] = '{"in1_2p5",   0, 1, 35'h0, 35'h14, 1, 0, 1, 1, 32'd3, 1, 0, 16'd0};
      vecs[2] = '{"rr_a",      1, 1, 35'h10, 35'h1C, 1, 1, 0, 1, 32'd2, 0, 0, 16'd0};
      vecs[3] = '{"rr_b",      1, 1, 35'h10, 35'h1C, 1, 0, 1, 1, 32'd4, 1, 0, 16'd0};
      vecs[4] = '{"rr_c",      1, 1, 35'h10, 35'h1C, 1, 1, 0, 1, 32'd2, 0, 0, 16'd0};
      vecs[5] = '{"rr_d",      1, 1, 35'h10, 35'h1C, 1, 0, 1, 1, 32'd4, 1, 0, 16'd0};
      vecs[6] = '{"sat",       1, 0, 35'h7_FFFF_FFFF, 35'h0, 1, 1, 0, 1, 32'hFFFF_FFFF, 0, 1, 16'd1};
      vecs[7] = '{"idle",      0, 0, 35'h0, 35'h0, 1, 0, 0, 0, 32'hFFFF_FFFF, 0, 1, 16'd1};
      vecs[8] = '{"max_nornd", 0, 1, 35'h0, 35'h7_FFFF_FFFB, 1, 0, 1, 1, 32'hFFFF_FFFF, 1, 0, 16'd1};
      vecs[9] = '{"rnd_down",  1, 0, 35'h1B, 35'h0, 1, 1, 0, 1, 32'd3, 0, 0, 16'd1};

      // Reset state, with both requesters asking
      resetn = 1'b0;
      drive(1, 1, 35'h13, 35'h14, 1);
      #2;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data",  64'(bus.out_data),  64'd0);
      chk("rst_out_src",   64'(bus.out_src),   64'd0);
      chk("rst_out_sat",   64'(bus.out_sat),   64'd0);
      chk("rst_sat_count", 64'(sat_count),     64'd0);
      chk("rst_in0_ready", 64'(bus.in0_ready), 64'd0);
      chk("rst_in1_ready", 64'(bus.in1_ready), 64'd0);
      #10;
      resetn = 1'b1;

      // Directed table
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].v0, vecs[i].v1, vecs[i].d0, vecs[i].d1, vecs[i].ordy);
         #1;
         chk({vecs[i].name, ".in0_ready"}, 64'(bus.in0_ready), 64'(vecs[i].r0));
         chk({vecs[i].name, ".in1_ready"}, 64'(bus.in1_ready), 64'(vecs[i].r1));
         @(posedge clk);
         #1;
         chk({vecs[i].name, ".out_valid"}, 64'(bus.out_valid), 64'(vecs[i].ov));
         chk({vecs[i].name, ".out_data"},  64'(bus.out_data),  64'(vecs[i].od));
         chk({vecs[i].name, ".out_src"},   64'(bus.out_src),   64'(vecs[i].os));
         chk({vecs[i].name, ".out_sat"},   64'(bus.out_sat),   64'(vecs[i].osat));
         chk({vecs[i].name, ".sat_count"}, 64'(sat_count),     64'(vecs[i].cnt));
      end

      // Backpressure: load from in1 (last grant was in0), stall 3 cycles, release
      drive(1, 1, 35'h20, 35'h2C, 1);
      tick();
      chk("bp_load_src",  64'(bus.out_src),  64'd1);
      chk("bp_load_data", 64'(bus.out_data), 64'd6);
      drive(1, 1, 35'h20, 35'h2C, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_stall_in0_ready", 64'(bus.in0_ready), 64'd0);
         chk("bp_stall_in1_ready", 64'(bus.in1_ready), 64'd0);
         @(posedge clk);
         #1;
         chk("bp_stall_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_stall_data",  64'(bus.out_data),  64'd6);
         chk("bp_stall_src",   64'(bus.out_src),   64'd1);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_rel_in0_ready", 64'(bus.in0_ready), 64'd1);
      chk("bp_rel_in1_ready", 64'(bus.in1_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("bp_rel_src",  64'(bus.out_src),  64'd0);
      chk("bp_rel_data", 64'(bus.out_data), 64'd4);

      // Mid-operation reset with a result pending and sat_count nonzero
      drive(1, 0, 35'h13, 35'h0, 0);
      resetn = 1'b0;
      #1;
      chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mrst_sat_count", 64'(sat_count),     64'd0);
      chk("mrst_out_data",  64'(bus.out_data),  64'd0);
      chk("mrst_in0_ready", 64'(bus.in0_ready), 64'd0);
      #1;
      resetn = 1'b1;
      drive(1, 1, 35'h13, 35'h14, 1);
      #1;
      chk("mrst_first_in0_ready", 64'(bus.in0_ready), 64'd1);
      chk("mrst_first_in1_ready", 64'(bus.in1_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("mrst_first_src",   64'(bus.out_src),   64'd0);
      chk("mrst_first_data",  64'(bus.out_data),  64'd2);
      chk("mrst_first_valid", 64'(bus.out_valid), 64'd1);

      // Randomized phase against the reference model, from a fresh reset
      resetn = 1'b0;
      drive(0, 0, '0, '0, 0);
      #2;
      resetn = 1'b1;
      model_reset();
      for (int n = 0; n < 400; n++) begin
         v0   = 1'($urandom_range(0, 1));
         v1   = 1'($urandom_range(0, 1));
         ordy = ($urandom_range(0, 3) != 0);
         d0   = ($urandom_range(0, 2) == 0) ? (35'h7_FFFF_FFF8 | 35'($urandom_range(0, 7)))
                                            : {3'($urandom_range(0, 7)), 32'($urandom)};
         d1   = ($urandom_range(0, 2) == 0) ? (35'h7_FFFF_FFF8 | 35'($urandom_range(0, 7)))
                                            : {3'($urandom_range(0, 7)), 32'($urandom)};
         drive(v0, v1, d0, d1, ordy);

         g = -1;
         if (!m_valid || ordy) begin
            if (v0 && v1)  g = (m_last == 0) ? 1 : 0;
            else if (v0)   g = 0;
            else if (v1)   g = 1;
         end
         e0 = (g == 0);
         e1 = (g == 1);
         #1;
         chk("rnd_in0_ready", 64'(bus.in0_ready), 64'(e0));
         chk("rnd_in1_ready", 64'(bus.in1_ready), 64'(e1));
         @(posedge clk);
         #1;

         if (g >= 0) begin
            model_div((g == 1) ? d1 : d0, q, s);
            m_valid = 1'b1;
            m_data  = q;
            m_src   = (g == 1);
            m_sat   = s;
            m_last  = g;
            if (s && m_cnt < 65535) m_cnt++;
         end else if (ordy) begin
            m_valid = 1'b0;
         end

         chk("rnd_out_valid", 64'(bus.out_valid), 64'(m_valid));
         chk("rnd_sat_count", 64'(sat_count),     64'(m_cnt));
         if (m_valid) begin
            chk("rnd_out_data", 64'(bus.out_data), 64'(m_data));
            chk("rnd_out_src",  64'(bus.out_src),  64'(m_src));
            chk("rnd_out_sat",  64'(bus.out_sat),  64'(m_sat));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
